// File: rtl/dual_grant_sequencer_if.sv
// Grant-sequencer bus: request/pending vector, encoder codes coming back,
// and the grant valid/ready handshake with its status outputs.
//   master : the sequencer (drives pend, grant outputs, busy, gnt_cnt)
//   slave  : requester / encoder / grant consumer side
interface dual_grant_sequencer_if #(
    parameter int N_REQ  = 12,
    parameter int CODE_W = 4,
    parameter int CNT_W  = 8
) ();
    logic [N_REQ-1:0]  req_in;
    logic [N_REQ-1:0]  pend;
    logic [CODE_W-1:0] first;
    logic [CODE_W-1:0] second;
    logic              gnt_valid;
    logic              gnt_ready;
    logic [CODE_W-1:0] gnt_code;
    logic [N_REQ-1:0]  gnt_onehot;
    logic              busy;
    logic [CNT_W-1:0]  gnt_cnt;

    modport master (
        input  req_in, first, second, gnt_ready,
        output pend, gnt_valid, gnt_code, gnt_onehot, busy, gnt_cnt
    );

    modport slave (
        output req_in, first, second, gnt_ready,
        input  pend, gnt_valid, gnt_code, gnt_onehot, busy, gnt_cnt
    );
endinterface

// File: rtl/dual_grant_sequencer.sv
// Dual grant sequencer.
// Holds sticky pending bits for N_REQ request lines, presents them to an
// external dual-priority encoder, and issues up to two grants per round
// (encoder first code, then second code) over a valid/ready handshake.
// Accepted grants clear their pending bit and bump a wrapping counter.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - dual_grant_sequencer_if.master (req_in/pend, first/second,
//          gnt_valid/gnt_ready/gnt_code/gnt_onehot, busy, gnt_cnt)
//
// state | meaning
// IDLE  | no grant offered; evaluates encoder codes for a new round
// G1    | offering first_q, waiting for accept
// G2    | offering second_q, waiting for accept
module dual_grant_sequencer #(
    parameter int N_REQ  = 12,
    parameter int CODE_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dual_grant_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_G1   = 2'd1,
        S_G2   = 2'd2
    } state_t;

    localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(N_REQ);

    state_t            r_state;
    state_t            w_next;
    logic [N_REQ-1:0]  r_pend;
    logic [CODE_W-1:0] r_first_q;
    logic [CODE_W-1:0] r_second_q;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_first_ok;
    logic              w_second_ok;
    logic              w_valid;
    logic [CODE_W-1:0] w_code;
    logic [N_REQ-1:0]  w_onehot;
    logic              w_accept;
    logic [N_REQ-1:0]  w_clr;

    function automatic logic [N_REQ-1:0] f_onehot(input logic [CODE_W-1:0] code);
        logic [N_REQ-1:0] v;
        v = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (code == CODE_W'(k)) v[k-1] = 1'b1;
        end
        return v;
    endfunction

    // Out-of-range encoder codes are treated as "no request".
    assign w_first_ok  = (bus.first  != '0) && (bus.first  <= MAX_CODE);
    assign w_second_ok = (bus.second != '0) && (bus.second <= MAX_CODE);

    assign w_accept = w_valid & bus.gnt_ready;
    assign w_clr    = w_accept ? w_onehot : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_first_ok) w_next = S_G1;
            S_G1:   if (w_accept)   w_next = (r_second_q != '0) ? S_G2 : S_IDLE;
            S_G2:   if (w_accept)   w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // Output logic: decoded only from registered state and captured codes
    always_comb begin
        w_valid = 1'b0;
        w_code  = '0;
        case (r_state)
            S_G1: begin
                w_valid = 1'b1;
                w_code  = r_first_q;
            end
            S_G2: begin
                w_valid = 1'b1;
                w_code  = r_second_q;
            end
            default: begin
                w_valid = 1'b0;
                w_code  = '0;
            end
        endcase
        w_onehot = f_onehot(w_code);
    end

    // Datapath: pending vector, round capture, grant counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= '0;
            r_first_q  <= '0;
            r_second_q <= '0;
            r_cnt      <= '0;
        end else begin
            // A set on the same edge as a clear wins, so a re-request is never lost.
            r_pend <= (r_pend & ~w_clr) | bus.req_in;
            // Codes are sampled only at round start; later requests wait for the next round.
            if (r_state == S_IDLE && w_first_ok) begin
                r_first_q  <= bus.first;
                r_second_q <= w_second_ok ? bus.second : '0;
            end
            if (w_accept) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.pend       = r_pend;
    assign bus.gnt_valid  = w_valid;
    assign bus.gnt_code   = w_code;
    assign bus.gnt_onehot = w_onehot;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.gnt_cnt    = r_cnt;
endmodule

// File: tb/tb_dual_grant_sequencer.sv
module tb_dual_grant_sequencer;
    localparam int N_REQ  = 12;
    localparam int CODE_W = 4;
    localparam int CNT_W  = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic              ov_en;
    logic [CODE_W-1:0] ov_first;
    logic [CODE_W-1:0] ov_second;

    dual_grant_sequencer_if #(.N_REQ(N_REQ), .CODE_W(CODE_W), .CNT_W(CNT_W)) bus ();

    dual_grant_sequencer #(.N_REQ(N_REQ), .CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference dual-priority encoder: highest set bit first, next-highest second.
    always_comb begin
        logic [CODE_W-1:0] f;
        logic [CODE_W-1:0] s;
        f = '0;
        s = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.pend[k]) begin
                if (f == '0)      f = CODE_W'(k + 1);
                else if (s == '0) s = CODE_W'(k + 1);
            end
        end
        bus.first  = ov_en ? ov_first  : f;
        bus.second = ov_en ? ov_second : s;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_in = 12'hFFF;
        bus.gnt_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        bus.req_in = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_in = 12'hFFF;
        bus.gnt_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.pend !== 12'h000) begin n_err++; $display("FAIL reset_pend: got %h want 000", bus.pend); end
        n_cmp++; if (bus.gnt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.gnt_valid); end
        n_cmp++; if (bus.gnt_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bus.gnt_cnt); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        rst = 1'b0;
        bus.req_in = '0;
    endtask

    task automatic test_two_grants();
        do_reset();
        bus.req_in = 12'h801;
        tick();
        bus.req_in = '0;
        bus.gnt_ready = 1'b1;
        n_cmp++; if (bus.pend !== 12'h801) begin n_err++; $display("FAIL two_pend_set: got %h want 801", bus.pend); end
        tick();
        n_cmp++; if (bus.gnt_valid !== 1'b1 || bus.gnt_code !== 4'hC) begin n_err++; $display("FAIL two_g1_code: got v=%b code=%h want v=1 code=c", bus.gnt_valid, bus.gnt_code); end
        n_cmp++; if (bus.gnt_onehot !== 12'h800) begin n_err++; $display("FAIL two_g1_onehot: got %h want 800", bus.gnt_onehot); end
        tick();
        n_cmp++; if (bus.gnt_valid !== 1'b1 || bus.gnt_code !== 4'h1) begin n_err++; $display("FAIL two_g2_code: got v=%b code=%h want v=1 code=1", bus.gnt_valid, bus.gnt_code); end
        n_cmp++; if (bus.gnt_onehot !== 12'h001) begin n_err++; $display("FAIL two_g2_onehot: got %h want 001", bus.gnt_onehot); end
        tick();
        n_cmp++; if (bus.pend !== 12'h000) begin n_err++; $display("FAIL two_pend_clr: got %h want 000", bus.pend); end
        n_cmp++; if (bus.gnt_cnt !== 8'd2) begin n_err++; $display("FAIL two_cnt: got %0d want 2", bus.gnt_cnt); end
        n_cmp++; if (bus.busy !== 1'b0 || bus.gnt_valid !== 1'b0 || bus.gnt_onehot !== 12'h000) begin n_err++; $display("FAIL two_idle: got busy=%b v=%b oh=%h want 0 0 000", bus.busy, bus.gnt_valid, bus.gnt_onehot); end
        bus.gnt_ready = 1'b0;
    endtask

    task automatic test_single_grant();
        do_reset();
        bus.req_in = 12'h020;
        tick();
        bus.req_in = '0;
        bus.gnt_ready = 1'b1;
        tick();
        n_cmp++; if (bus.gnt_valid !== 1'b1 || bus.gnt_code !== 4'h6) begin n_err++; $display("FAIL single_code: got v=%b code=%h want v=1 code=6", bus.gnt_valid, bus.gnt_code); end
        tick();
        n_cmp++; if (bus.busy !== 1'b0 || bus.gnt_valid !== 1'b0) begin n_err++; $display("FAIL single_no_g2: got busy=%b v=%b want 0 0", bus.busy, bus.gnt_valid); end
        tick();
        n_cmp++; if (bus.gnt_valid !== 1'b0 || bus.gnt_cnt !== 8'd1) begin n_err++; $display("FAIL single_after: got v=%b cnt=%0d want v=0 cnt=1", bus.gnt_valid, bus.gnt_cnt); end
        bus.gnt_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.req_in = 12'h300;
        tick();
        bus.req_in = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.gnt_valid !== 1'b1 || bus.gnt_code !== 4'hA) begin n_err++; $display("FAIL bp_hold%0d: got v=%b code=%h want v=1 code=a", i, bus.gnt_valid, bus.gnt_code); end
            tick();
        end
        bus.gnt_ready = 1'b1;
        tick();
        n_cmp++; if (bus.gnt_valid !== 1'b1 || bus.gnt_code !== 4'h9) begin n_err++; $display("FAIL bp_second: got v=%b code=%h want v=1 code=9", bus.gnt_valid, bus.gnt_code); end
        tick();
        n_cmp++; if (bus.gnt_cnt !== 8'd2 || bus.busy !== 1'b0) begin n_err++; $display("FAIL bp_done: got cnt=%0d busy=%b want cnt=2 busy=0", bus.gnt_cnt, bus.busy); end
        bus.gnt_ready = 1'b0;
    endtask

    task automatic test_set_wins_clear();
        do_reset();
        bus.req_in = 12'h008;
        tick();
        bus.req_in = '0;
        tick();
        n_cmp++; if (bus.gnt_code !== 4'h4) begin n_err++; $display("FAIL swc_g1: got %h want 4", bus.gnt_code); end
        bus.gnt_ready = 1'b1;
        bus.req_in = 12'h008;
        tick();
        bus.gnt_ready = 1'b0;
        bus.req_in = '0;
        n_cmp++; if (bus.pend !== 12'h008 || bus.gnt_cnt !== 8'd1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL swc_kept: got pend=%h cnt=%0d busy=%b want 008 1 0", bus.pend, bus.gnt_cnt, bus.busy); end
        tick();
        n_cmp++; if (bus.gnt_valid !== 1'b1 || bus.gnt_code !== 4'h4) begin n_err++; $display("FAIL swc_regrant: got v=%b code=%h want v=1 code=4", bus.gnt_valid, bus.gnt_code); end
        bus.gnt_ready = 1'b1;
        tick();
        bus.gnt_ready = 1'b0;
        n_cmp++; if (bus.pend !== 12'h000 || bus.gnt_cnt !== 8'd2) begin n_err++; $display("FAIL swc_final: got pend=%h cnt=%0d want 000 2", bus.pend, bus.gnt_cnt); end
    endtask

    task automatic test_reset_in_g2();
        do_reset();
        bus.req_in = 12'h801;
        tick();
        bus.req_in = '0;
        tick();
        bus.gnt_ready = 1'b1;
        tick();
        bus.gnt_ready = 1'b0;
        n_cmp++; if (bus.gnt_code !== 4'h1 || bus.gnt_cnt !== 8'd1) begin n_err++; $display("FAIL rstg2_pre: got code=%h cnt=%0d want 1 1", bus.gnt_code, bus.gnt_cnt); end
        bus.req_in = 12'h010;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_in = '0;
        n_cmp++; if (bus.busy !== 1'b0 || bus.gnt_valid !== 1'b0 || bus.pend !== 12'h000) begin n_err++; $display("FAIL rstg2_state: got busy=%b v=%b pend=%h want 0 0 000", bus.busy, bus.gnt_valid, bus.pend); end
        n_cmp++; if (bus.gnt_cnt !== 8'd0 || bus.gnt_code !== 4'h0 || bus.gnt_onehot !== 12'h000) begin n_err++; $display("FAIL rstg2_out: got cnt=%0d code=%h oh=%h want 0 0 000", bus.gnt_cnt, bus.gnt_code, bus.gnt_onehot); end
    endtask

    task automatic test_bad_codes();
        do_reset();
        ov_en = 1'b1;
        ov_first = 4'hD;
        ov_second = 4'h3;
        tick();
        tick();
        n_cmp++; if (bus.gnt_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL bad_first: got v=%b busy=%b want 0 0", bus.gnt_valid, bus.busy); end
        ov_first = 4'h2;
        ov_second = 4'hF;
        tick();
        ov_first = 4'h0;
        ov_second = 4'h0;
        n_cmp++; if (bus.gnt_valid !== 1'b1 || bus.gnt_code !== 4'h2 || bus.gnt_onehot !== 12'h002) begin n_err++; $display("FAIL bad_g1: got v=%b code=%h oh=%h want 1 2 002", bus.gnt_valid, bus.gnt_code, bus.gnt_onehot); end
        bus.gnt_ready = 1'b1;
        tick();
        bus.gnt_ready = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0 || bus.gnt_cnt !== 8'd1) begin n_err++; $display("FAIL bad_second: got busy=%b cnt=%0d want 0 1", bus.busy, bus.gnt_cnt); end
        ov_en = 1'b0;
    endtask

    task automatic test_cnt_wrap();
        int n_acc;
        n_acc = 0;
        do_reset();
        bus.gnt_ready = 1'b1;
        bus.req_in = 12'h001;
        for (int i = 0; i < 2000 && n_acc < 256; i++) begin
            tick();
            if (bus.gnt_valid === 1'b1) n_acc++;
        end
        n_cmp++;
        if (n_acc != 256) begin
            n_err++;
            $display("FAIL wrap_timeout: got %0d accepts want 256", n_acc);
        end else begin
            if (bus.gnt_cnt !== 8'd255) begin n_err++; $display("FAIL wrap_pre: got %0d want 255", bus.gnt_cnt); end
            bus.req_in = '0;
            tick();
            n_cmp++; if (bus.gnt_cnt !== 8'd0) begin n_err++; $display("FAIL wrap_post: got %0d want 0", bus.gnt_cnt); end
        end
        bus.req_in = '0;
        bus.gnt_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        ov_en = 1'b0;
        ov_first = '0;
        ov_second = '0;
        rst = 1'b1;
        bus.req_in = '0;
        bus.gnt_ready = 1'b0;
        tick();
        test_reset();
        test_two_grants();
        test_single_grant();
        test_backpressure();
        test_set_wins_clear();
        test_reset_in_g2();
        test_bad_codes();
        test_cnt_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
